// File: rtl/rec2pol_pkg.sv
// Shared types and constants for the rec2pol scheduler and the CORDIC core it drives.
package rec2pol_pkg;

    localparam int DATAW           = 32;
    localparam int REC2POL_LATENCY = 33;
    localparam int FRAC_MOD        = 16;
    localparam int FRAC_ANGLE      = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rec2pol_sched_rr_arb.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr wins.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int TAGW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [TAGW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [TAGW-1:0] idx,
    output logic            any
);

    logic [NREQ-1:0] w_rot;
    logic [TAGW:0]   w_sum;

    // Rotate so that bit 0 is the requester sitting at ptr.
    assign w_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        w_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && w_rot[k]) begin
                any   = 1'b1;
                w_sum = {1'b0, ptr} + (TAGW+1)'(k);
                if (w_sum >= (TAGW+1)'(NREQ)) begin
                    w_sum = w_sum - (TAGW+1)'(NREQ);
                end
                idx = w_sum[TAGW-1:0];
                gnt = NREQ'(1) << w_sum[TAGW-1:0];
            end
        end
    end

endmodule

// File: rtl/rec2pol_sched.sv
// Shares one rec2pol CORDIC core among NREQ requesters: arbitrate, start, wait fixed latency,
// capture results and return them tagged with the requester index.
module rec2pol_sched
    import rec2pol_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = REC2POL_LATENCY,
    parameter int TAGW    = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*DATAW-1:0] req_x,
    input  logic [NREQ*DATAW-1:0] req_y,
    output logic                  core_enable,
    output logic                  core_start,
    output logic [DATAW-1:0]      core_x,
    output logic [DATAW-1:0]      core_y,
    input  logic [DATAW-1:0]      core_mod,
    input  logic [DATAW-1:0]      core_angle,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [TAGW-1:0]       res_tag,
    output logic [DATAW-1:0]      res_mod,
    output logic [DATAW-1:0]      res_angle,
    output logic                  busy
);

    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [TAGW-1:0]  r_ptr;
    logic [TAGW-1:0]  r_tag;
    logic [CNTW-1:0]  r_cnt;
    logic [DATAW-1:0] r_x;
    logic [DATAW-1:0] r_y;
    logic [DATAW-1:0] r_mod;
    logic [DATAW-1:0] r_angle;
    logic [NREQ-1:0]  w_gnt;
    logic [TAGW-1:0]  w_idx;
    logic             w_any;

    rr_arb #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A grant in IDLE is a transfer: the grant is derived from req_valid itself.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = DONE;
            DONE:    if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        core_start  = 1'b0;
        core_enable = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                req_ready = w_gnt;
                busy      = 1'b0;
            end
            START: begin
                core_start  = 1'b1;
                core_enable = 1'b1;
            end
            WAIT:    core_enable = 1'b1;
            DONE:    res_valid   = 1'b1;
            default: busy        = 1'b0;
        endcase
    end

    // Operand, tag and result registers; core_x/core_y hold until the next transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_tag   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_mod   <= '0;
            r_angle <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_x   <= req_x[w_idx*DATAW +: DATAW];
                        r_y   <= req_y[w_idx*DATAW +: DATAW];
                        r_tag <= w_idx;
                        r_ptr <= (w_idx == TAGW'(NREQ-1)) ? '0 : w_idx + TAGW'(1);
                    end
                end
                START: r_cnt <= CNTW'(LATENCY-1);
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_mod   <= core_mod;
                        r_angle <= core_angle;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_x    = r_x;
    assign core_y    = r_y;
    assign res_tag   = r_tag;
    assign res_mod   = r_mod;
    assign res_angle = r_angle;

endmodule
